lc3b_decode_stage: RTL

- LC-3b pipeline decode (ID) stage.
- Accepts fetched instructions from IF over a valid/ready handshake and decodes each into the packed lc3b_control_word plus register specifiers.
- Holds the result in the ID/EX pipeline register for the execute stage.
- A 1-entry skid buffer keeps if_ready registered.
- A flush input squashes in-flight instructions on a redirect.

---
 rtl/lc3b_decode_stage.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/lc3b_decode_stage.sv
// LC-3b decode (ID) stage: takes instructions from IF over valid/ready,
// decodes them into the packed control word and register specifiers, and
// holds the result in the ID/EX register. A one-entry skid buffer lets
// if_ready come straight from a flop.
module lc3b_decode_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [15:0] if_instr,
   input  logic [15:0] if_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [19:0] id_ctrl,
   output logic [15:0] id_instr,
   output logic [15:0] id_pc,
   output logic [2:0]  id_sr1,
   output logic [2:0]  id_sr2,
   output logic [2:0]  id_dest
);

   typedef enum logic [3:0] {
      OP_BR   = 4'h0,
      OP_ADD  = 4'h1,
      OP_LDB  = 4'h2,
      OP_STB  = 4'h3,
      OP_JSR  = 4'h4,
      OP_AND  = 4'h5,
      OP_LDR  = 4'h6,
      OP_STR  = 4'h7,
      OP_RTI  = 4'h8,
      OP_NOT  = 4'h9,
      OP_LDI  = 4'hA,
      OP_STI  = 4'hB,
      OP_JMP  = 4'hC,
      OP_SHF  = 4'hD,
      OP_LEA  = 4'hE,
      OP_TRAP = 4'hF
   } lc3b_opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_AND  = 4'd1,
      ALU_NOT  = 4'd2,
      ALU_PASS = 4'd3,
      ALU_SLL  = 4'd4,
      ALU_SRL  = 4'd5,
      ALU_SRA  = 4'd6
   } lc3b_aluop_e;

   typedef struct packed {
      lc3b_opcode_e opcode;
      logic         load_cc;
      logic         load_regfile;
      lc3b_aluop_e  aluop;
      logic         addr1mux_sel;
      logic [1:0]   addr2mux_sel;
      logic         sr2mux_sel;
      logic         memaddrmux_sel;
      logic         drmux_sel;
      logic [3:0]   reserved;
   } lc3b_control_word;

   logic        skid_valid;
   logic [15:0] skid_instr;
   logic [15:0] skid_pc;

   logic        if_xfer;
   logic        id_load;
   logic        src_valid;
   logic [15:0] src_instr;
   logic [15:0] src_pc;

   lc3b_opcode_e     src_op;
   lc3b_control_word dec_ctrl;
   logic [2:0]       dec_sr2;
   logic [2:0]       dec_dest;

   assign if_ready  = ~skid_valid;
   assign if_xfer   = if_valid & if_ready;
   assign id_load   = ~id_valid | id_ready;
   assign src_valid = skid_valid | if_xfer;
   assign src_instr = skid_valid ? skid_instr : if_instr;
   assign src_pc    = skid_valid ? skid_pc : if_pc;
   assign src_op    = lc3b_opcode_e'(src_instr[15:12]);

   // Decode the selected source instruction into control word and specifiers
   always_comb begin
      dec_ctrl        = '0;
      dec_ctrl.opcode = src_op;
      dec_sr2         = src_instr[2:0];
      dec_dest        = src_instr[11:9];
      unique case (src_op)
         OP_ADD, OP_AND: begin
            dec_ctrl.load_cc      = 1'b1;
            dec_ctrl.load_regfile = 1'b1;
            dec_ctrl.aluop        = (src_op == OP_AND) ? ALU_AND : ALU_ADD;
            dec_ctrl.sr2mux_sel   = src_instr[5];
         end
         OP_NOT: begin
            dec_ctrl.load_cc      = 1'b1;
            dec_ctrl.load_regfile = 1'b1;
            dec_ctrl.aluop        = ALU_NOT;
         end
         OP_SHF: begin
            dec_ctrl.load_cc      = 1'b1;
            dec_ctrl.load_regfile = 1'b1;
            dec_ctrl.sr2mux_sel   = 1'b1;
            if (!src_instr[4])
               dec_ctrl.aluop = ALU_SLL;
            else if (src_instr[5])
               dec_ctrl.aluop = ALU_SRA;
            else
               dec_ctrl.aluop = ALU_SRL;
         end
         OP_LDR, OP_LDB, OP_LDI: begin
            dec_ctrl.load_cc        = 1'b1;
            dec_ctrl.load_regfile   = 1'b1;
            dec_ctrl.aluop          = ALU_PASS;
            dec_ctrl.addr1mux_sel   = 1'b1;
            dec_ctrl.addr2mux_sel   = 2'b01;
            dec_ctrl.memaddrmux_sel = 1'b1;
            dec_ctrl.drmux_sel      = 1'b1;
         end
         OP_STR, OP_STB, OP_STI: begin
            dec_ctrl.addr1mux_sel   = 1'b1;
            dec_ctrl.addr2mux_sel   = 2'b01;
            dec_ctrl.memaddrmux_sel = 1'b1;
            // stores read the data register through the second read port
            dec_sr2                 = src_instr[11:9];
         end
         OP_LEA: begin
            dec_ctrl.load_regfile = 1'b1;
            dec_ctrl.addr2mux_sel = 2'b10;
            dec_ctrl.drmux_sel    = 1'b1;
         end
         OP_BR: begin
            dec_ctrl.addr2mux_sel = 2'b10;
         end
         OP_JMP: begin
            dec_ctrl.addr1mux_sel = 1'b1;
            dec_ctrl.addr2mux_sel = 2'b00;
         end
         OP_JSR: begin
            dec_ctrl.load_regfile = 1'b1;
            dest_link_jsr: begin
               if (src_instr[11]) begin
                  dec_ctrl.addr2mux_sel = 2'b11;
               end else begin
                  dec_ctrl.addr1mux_sel = 1'b1;
                  dec_ctrl.addr2mux_sel = 2'b00;
               end
            end
            dec_dest = 3'd7;
         end
         OP_TRAP: begin
            dec_ctrl.load_regfile = 1'b1;
            dec_dest              = 3'd7;
         end
         OP_RTI: begin
            dec_ctrl.opcode = OP_RTI;
         end
         default: begin
            dec_ctrl.opcode = src_op;
         end
      endcase
   end

   // Skid buffer and ID/EX register; reset beats flush, flush beats any load
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_valid <= 1'b0;
         skid_instr <= '0;
         skid_pc    <= '0;
         id_valid   <= 1'b0;
         id_ctrl    <= '0;
         id_instr   <= '0;
         id_pc      <= '0;
         id_sr1     <= '0;
         id_sr2     <= '0;
         id_dest    <= '0;
      end else if (flush) begin
         skid_valid <= 1'b0;
         id_valid   <= 1'b0;
      end else begin
         if (id_load) begin
            id_valid <= src_valid;
            if (src_valid) begin
               id_ctrl  <= dec_ctrl;
               id_instr <= src_instr;
               id_pc    <= src_pc;
               id_sr1   <= src_instr[8:6];
               id_sr2   <= dec_sr2;
               id_dest  <= dec_dest;
            end
            // a waiting skid entry is always the one that moves forward
            if (skid_valid)
               skid_valid <= 1'b0;
         end else if (if_xfer) begin
            skid_valid <= 1'b1;
            skid_instr <= if_instr;
            skid_pc    <= if_pc;
         end
      end
   end

endmodule
